// File: rtl/segre_pkg.sv
// segre_pkg: shared types, sizes and helpers for the segre store buffer
package segre_pkg;
  localparam int ADDR_SIZE = 32;
  localparam int WORD_SIZE = 32;
  localparam int STORE_BUFFER_NUM_ELEMS = 2;
  typedef enum logic [1:0] {BYTE = 2'b00, HALF = 2'b01, WORD = 2'b10} memop_data_type_e;
  typedef struct packed {
    logic req_store;
    logic req_load;
    logic flush_chance;
    logic [ADDR_SIZE-1:0] addr;
    logic [WORD_SIZE-1:0] data;
    memop_data_type_e memop_data_type;
  } store_buffer_t;
  typedef struct packed {
    logic valid;
    logic [ADDR_SIZE-1:0] addr;
    logic [WORD_SIZE-1:0] data;
    memop_data_type_e memop_data_type;
  } sb_entry_t;
  function automatic logic [3:0] sb_byte_mask(input logic [1:0] a, input memop_data_type_e t);
    return t == BYTE ? 4'b0001 << a : t == HALF ? 4'b0011 << {a[1], 1'b0} : 4'hF;
  endfunction
endpackage

// File: rtl/segre_store_buffer.sv
// segre_store_buffer: FIFO of retired stores draining to the dcache, with load forwarding
// Ports: clk_i/rsn_i clock and async active-low reset; req_store_i pushes addr_i/data_i/type;
// req_load_i looks up addr_i/type giving hit_o (forwarded on data_o), miss_o or trouble_o;
// flush_chance_i lets the head drain via data_valid_o/addr_o/data_o/memop_data_type_o; full_o.
module segre_store_buffer import segre_pkg::*; #(
  parameter int NUM_ELEMS = STORE_BUFFER_NUM_ELEMS,
  parameter int ADDR_W = ADDR_SIZE,
  parameter int DATA_W = WORD_SIZE
) (
  input  logic clk_i,
  input  logic rsn_i,
  input  logic req_store_i,
  input  logic req_load_i,
  input  logic flush_chance_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  input  memop_data_type_e memop_data_type_i,
  output logic hit_o,
  output logic miss_o,
  output logic trouble_o,
  output logic full_o,
  output logic data_valid_o,
  output memop_data_type_e memop_data_type_o,
  output logic [DATA_W-1:0] data_o,
  output logic [ADDR_W-1:0] addr_o
);
  localparam int PTR_W = $clog2(NUM_ELEMS);
  localparam int CNT_W = PTR_W + 1;
  sb_entry_t mem [NUM_ELEMS];
  logic [PTR_W-1:0] head, tail, sel, idx;
  logic [CNT_W-1:0] count;
  logic push, found, same;
  assign full_o = count == CNT_W'(NUM_ELEMS);
  assign push = req_store_i & ~full_o;
  assign data_valid_o = flush_chance_i & (count != '0) & ~req_load_i;
  // Popped slots are zeroed whole so an empty buffer presents a clean head.
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      mem <= '{default: '0};
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[tail] <= '{valid: 1'b1, addr: addr_i, data: data_i, memop_data_type: memop_data_type_i};
        tail <= tail + 1'b1;
      end
      if (data_valid_o) begin
        mem[head] <= '0;
        head <= head + 1'b1;
      end
      count <= count + CNT_W'(push) - CNT_W'(data_valid_o);
    end
  end
  // Youngest-first search: the first valid overlapping entry walking back from tail wins.
  always_comb begin
    found = 1'b0;
    sel = head;
    idx = tail;
    for (int k = 1; k <= NUM_ELEMS; k++) begin
      idx = tail - PTR_W'(k);
      if (!found && mem[idx].valid && mem[idx].addr[ADDR_W-1:2] == addr_i[ADDR_W-1:2] &&
          |(sb_byte_mask(mem[idx].addr[1:0], mem[idx].memop_data_type) &
            sb_byte_mask(addr_i[1:0], memop_data_type_i))) begin
        found = 1'b1;
        sel = idx;
      end
    end
  end
  assign same = mem[sel].addr == addr_i && mem[sel].memop_data_type == memop_data_type_i;
  assign hit_o = req_load_i & found & same;
  assign trouble_o = req_load_i & found & ~same;
  assign miss_o = req_load_i & ~found;
  assign data_o = req_load_i ? (hit_o ? mem[sel].data : '0) : mem[head].data;
  assign addr_o = mem[head].addr;
  assign memop_data_type_o = mem[head].memop_data_type;
  always @(posedge clk_i) begin
    if (rsn_i) begin
      assert (!(req_store_i && full_o)) else $warning("store dropped: buffer full");
      assert (!(req_store_i && req_load_i)) else $error("store and load requested in the same cycle");
    end
  end
endmodule

// File: tb/tb_segre_store_buffer.sv
// tb_segre_store_buffer: directed and random checks of the store buffer against a queue model
module tb_segre_store_buffer;
  import segre_pkg::*;
  logic clk_i = 1'b0, rsn_i = 1'b0;
  logic req_store_i = 1'b0, req_load_i = 1'b0, flush_chance_i = 1'b0;
  logic [31:0] addr_i = '0, data_i = '0;
  memop_data_type_e memop_data_type_i = BYTE;
  logic hit_o, miss_o, trouble_o, full_o, data_valid_o;
  memop_data_type_e memop_data_type_o;
  logic [31:0] data_o, addr_o;
  typedef struct {logic [31:0] a; logic [31:0] d; memop_data_type_e t;} ent_t;
  ent_t q[$];
  int passed = 0, fails = 0, total = 0;

  segre_store_buffer dut (
    .clk_i(clk_i), .rsn_i(rsn_i), .req_store_i(req_store_i), .req_load_i(req_load_i),
    .flush_chance_i(flush_chance_i), .addr_i(addr_i), .data_i(data_i),
    .memop_data_type_i(memop_data_type_i), .hit_o(hit_o), .miss_o(miss_o),
    .trouble_o(trouble_o), .full_o(full_o), .data_valid_o(data_valid_o),
    .memop_data_type_o(memop_data_type_o), .data_o(data_o), .addr_o(addr_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int sz(memop_data_type_e t);
    return t == BYTE ? 1 : t == HALF ? 2 : 4;
  endfunction

  // Byte intervals [base, base+size) with base aligned down to the access size.
  function automatic bit overlaps(logic [31:0] a1, memop_data_type_e t1, logic [31:0] a2, memop_data_type_e t2);
    longint b1 = longint'(a1 & ~(sz(t1) - 1));
    longint b2 = longint'(a2 & ~(sz(t2) - 1));
    return b1 < b2 + sz(t2) && b2 < b1 + sz(t1);
  endfunction

  task automatic cycle(bit st, bit ld, bit fl, logic [31:0] a, logic [31:0] d, memop_data_type_e t);
    bit e_hit, e_miss, e_tr, e_dv, was_full, done;
    logic [31:0] e_data;
    req_store_i = st; req_load_i = ld; flush_chance_i = fl;
    addr_i = a; data_i = d; memop_data_type_i = t;
    @(negedge clk_i);
    e_hit = 0; e_miss = 0; e_tr = 0; e_data = 0; done = 0;
    if (ld) begin
      for (int i = q.size() - 1; i >= 0; i--)
        if (!done && overlaps(q[i].a, q[i].t, a, t)) begin
          done = 1;
          if (q[i].a == a && q[i].t == t) begin e_hit = 1; e_data = q[i].d; end
          else e_tr = 1;
        end
      e_miss = !done;
    end else if (q.size() != 0) e_data = q[0].d;
    was_full = q.size() == 2;
    e_dv = fl && q.size() != 0 && !ld;
    chk("hit", 32'(hit_o), 32'(e_hit));
    chk("miss", 32'(miss_o), 32'(e_miss));
    chk("trouble", 32'(trouble_o), 32'(e_tr));
    chk("full", 32'(full_o), 32'(was_full));
    chk("data_valid", 32'(data_valid_o), 32'(e_dv));
    chk("data", data_o, e_data);
    chk("addr", addr_o, q.size() != 0 ? q[0].a : 32'h0);
    chk("type", 32'(memop_data_type_o), q.size() != 0 ? 32'(q[0].t) : 32'(BYTE));
    @(posedge clk_i);
    if (e_dv) void'(q.pop_front());
    if (st && !was_full) q.push_back('{a, d, t});
    #1;
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_hit"}, 32'(hit_o), 0);
    chk({tag, "_miss"}, 32'(miss_o), 0);
    chk({tag, "_trouble"}, 32'(trouble_o), 0);
    chk({tag, "_full"}, 32'(full_o), 0);
    chk({tag, "_dv"}, 32'(data_valid_o), 0);
    chk({tag, "_data"}, data_o, 0);
    chk({tag, "_addr"}, addr_o, 0);
    chk({tag, "_type"}, 32'(memop_data_type_o), 32'(BYTE));
  endtask

  initial begin
    @(posedge clk_i); #1;
    check_zero("reset");
    @(posedge clk_i); #1;
    rsn_i = 1'b1;
    cycle(0, 1, 0, 32'h100, 0, WORD);
    cycle(1, 0, 0, 32'h100, 32'hDEADBEEF, WORD);
    cycle(0, 1, 0, 32'h100, 0, WORD);
    cycle(0, 1, 0, 32'h104, 0, BYTE);
    cycle(0, 0, 1, 0, 0, BYTE);
    cycle(1, 0, 0, 32'h200, 32'h11111111, WORD);
    cycle(1, 0, 0, 32'h200, 32'h22222222, WORD);
    cycle(0, 1, 0, 32'h200, 0, WORD);
    cycle(1, 0, 0, 32'h300, 32'h33333333, WORD);
    cycle(0, 1, 0, 32'h300, 0, WORD);
    cycle(0, 0, 1, 0, 0, BYTE);
    cycle(0, 0, 1, 0, 0, BYTE);
    cycle(1, 0, 0, 32'h102, 32'h0000ABCD, HALF);
    cycle(0, 1, 0, 32'h103, 0, BYTE);
    cycle(0, 1, 0, 32'h101, 0, BYTE);
    cycle(0, 1, 0, 32'h102, 0, HALF);
    cycle(0, 0, 1, 0, 0, BYTE);
    cycle(1, 0, 0, 32'h200, 32'hA0, WORD);
    cycle(1, 0, 0, 32'h204, 32'hA4, WORD);
    cycle(0, 0, 1, 0, 0, BYTE);
    cycle(0, 0, 1, 0, 0, BYTE);
    cycle(0, 0, 0, 0, 0, BYTE);
    cycle(1, 0, 0, 32'h400, 32'h40, WORD);
    cycle(1, 0, 0, 32'h404, 32'h44, HALF);
    cycle(1, 0, 1, 32'h408, 32'h48, BYTE);
    cycle(1, 0, 1, 32'h40C, 32'h4C, WORD);
    cycle(0, 0, 0, 0, 0, BYTE);
    cycle(1, 0, 0, 32'h500, 32'h50, WORD);
    req_store_i = 0; req_load_i = 0; flush_chance_i = 0;
    #2 rsn_i = 1'b0;
    #1 check_zero("midreset");
    q.delete();
    @(posedge clk_i); #1;
    rsn_i = 1'b1;
    cycle(0, 1, 0, 32'h40C, 0, WORD);
    for (int n = 0; n < 400; n++) begin
      int op = $urandom_range(0, 2);
      cycle(op == 0, op == 1, 1'($urandom_range(0, 1)), 32'h100 + 32'($urandom_range(0, 7)),
            $urandom, memop_data_type_e'($urandom_range(0, 2)));
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
